// File: rtl/module_mini_cpu_param.sv
// Mini CPU: KEY-release instruction capture into a FIFO, in-order execution on a register file
// with a shift-add multiplier, and results reported to an LCD controller over a busy handshake.
module module_mini_cpu_param #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int SIMM_W = 7,
    parameter int QDEPTH = 4,
    parameter int LCD_TO = 255,
    localparam int INSTR_W = 3 + 2 * REG_AW + SIMM_W,
    localparam int LIMM_W  = REG_AW + SIMM_W,
    localparam int QAW     = $clog2(QDEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                send_btn,
    input  logic [INSTR_W-1:0]  switches,
    input  logic                lcd_busy,
    output logic                lcd_update,
    output logic [2:0]          lcd_opcode,
    output logic [REG_AW-1:0]   lcd_reg_idx,
    output logic [DATA_W-1:0]   lcd_value,
    output logic                flag_z,
    output logic                flag_v,
    output logic [QAW:0]        q_count,
    output logic                q_full,
    output logic                instr_drop,
    output logic                cpu_busy
);
    localparam int NREGS = 2 ** REG_AW;
    localparam int MCW   = $clog2(DATA_W + 1);
    localparam int TOW   = $clog2(LCD_TO + 1);
    localparam logic [MCW-1:0] MUL_STEPS = MCW'(DATA_W);
    localparam logic [TOW-1:0] TO_LAST   = TOW'(LCD_TO - 1);
    localparam logic [QAW:0]   Q_FULL_N  = (QAW + 1)'(QDEPTH);

    localparam logic [2:0] OP_LOAD = 3'd0, OP_ADD = 3'd1, OP_ADDI = 3'd2, OP_SUB = 3'd3,
                           OP_SUBI = 3'd4, OP_MUL = 3'd5, OP_CLEAR = 3'd6, OP_DISP = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_MUL, S_EXEC, S_WRITE, S_PULSE, S_WAIT_HI, S_WAIT_LO
    } state_t;

    state_t                 r_state;
    logic [INSTR_W-1:0]     r_fifo [QDEPTH];
    logic [QAW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [QAW:0]           r_count;
    logic                   r_btn_prev;
    logic [DATA_W-1:0]      r_regs [NREGS];
    logic [INSTR_W-1:0]     r_instr;
    logic [DATA_W-1:0]      r_op_a, r_op_b, r_result;
    logic                   r_ovf;
    logic [2*DATA_W-1:0]    r_acc, r_mcand;
    logic [DATA_W-1:0]      r_mplier;
    logic                   r_neg;
    logic [MCW-1:0]         r_mcnt;
    logic [TOW-1:0]         r_to;

    logic                   w_release, w_pop, w_push;
    logic [2:0]             w_op;
    logic [REG_AW-1:0]      w_rd, w_rs1, w_rs2;
    logic [DATA_W-1:0]      w_a, w_b, w_a_mag, w_b_mag, w_simm_x, w_limm_x;
    logic [DATA_W-1:0]      w_alu_res;
    logic                   w_alu_ovf;
    logic [2*DATA_W-1:0]    w_prod;
    logic                   w_mul_ovf;

    assign w_release = !r_btn_prev && send_btn;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0) && !lcd_busy;
    assign w_push    = w_release && (!q_full || w_pop);

    assign q_count   = r_count;
    assign q_full    = (r_count == Q_FULL_N);
    assign cpu_busy  = (r_state != S_IDLE);

    assign w_op     = r_instr[INSTR_W-1 -: 3];
    assign w_rd     = r_instr[INSTR_W-4 -: REG_AW];
    assign w_rs1    = r_instr[SIMM_W+REG_AW-1 -: REG_AW];
    assign w_rs2    = r_instr[SIMM_W-1 -: REG_AW];
    assign w_simm_x = DATA_W'($signed(r_instr[SIMM_W-1:0]));
    assign w_limm_x = DATA_W'($signed(r_instr[LIMM_W-1:0]));

    assign w_a     = r_regs[w_rs1];
    assign w_b     = r_regs[w_rs2];
    assign w_a_mag = w_a[DATA_W-1] ? -w_a : w_a;
    assign w_b_mag = w_b[DATA_W-1] ? -w_b : w_b;

    // Full-width signed product; overflow when it differs from the sign extension of its low half.
    assign w_prod    = r_neg ? -r_acc : r_acc;
    assign w_mul_ovf = (w_prod != {{DATA_W{w_prod[DATA_W-1]}}, w_prod[DATA_W-1:0]});

    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (w_op)
            OP_LOAD: w_alu_res = r_op_b;
            OP_ADD, OP_ADDI: begin
                w_alu_res = r_op_a + r_op_b;
                w_alu_ovf = (r_op_a[DATA_W-1] == r_op_b[DATA_W-1]) &&
                            (w_alu_res[DATA_W-1] != r_op_a[DATA_W-1]);
            end
            OP_SUB, OP_SUBI: begin
                w_alu_res = r_op_a - r_op_b;
                w_alu_ovf = (r_op_a[DATA_W-1] != r_op_b[DATA_W-1]) &&
                            (w_alu_res[DATA_W-1] != r_op_a[DATA_W-1]);
            end
            OP_DISP: w_alu_res = r_op_a;
            default: w_alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_btn_prev <= 1'b1;
            instr_drop <= 1'b0;
        end else begin
            r_btn_prev <= send_btn;
            instr_drop <= w_release && !w_push;
            if (w_push) begin
                r_fifo[r_wr_ptr] <= switches;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
            r_instr     <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_neg       <= 1'b0;
            r_mcnt      <= '0;
            r_to        <= '0;
            lcd_update  <= 1'b0;
            lcd_opcode  <= '0;
            lcd_reg_idx <= '0;
            lcd_value   <= '0;
            flag_z      <= 1'b0;
            flag_v      <= 1'b0;
        end else begin
            lcd_update <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_instr <= r_fifo[r_rd_ptr];
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_op_a <= w_a;
                    if (w_op == OP_ADD || w_op == OP_SUB)
                        r_op_b <= w_b;
                    else if (w_op == OP_LOAD)
                        r_op_b <= w_limm_x;
                    else
                        r_op_b <= w_simm_x;
                    r_acc    <= '0;
                    r_mcand  <= {{DATA_W{1'b0}}, w_a_mag};
                    r_mplier <= w_b_mag;
                    r_neg    <= w_a[DATA_W-1] ^ w_b[DATA_W-1];
                    r_mcnt   <= '0;
                    r_state  <= (w_op == OP_MUL) ? S_MUL : S_EXEC;
                end
                // DATA_W shift-add steps on magnitudes, then one cycle to apply the sign.
                S_MUL: begin
                    if (r_mcnt != MUL_STEPS) begin
                        if (r_mplier[0])
                            r_acc <= r_acc + r_mcand;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_mcnt   <= r_mcnt + 1'b1;
                    end else begin
                        r_result <= w_prod[DATA_W-1:0];
                        r_ovf    <= w_mul_ovf;
                        r_state  <= S_WRITE;
                    end
                end
                S_EXEC: begin
                    r_result <= w_alu_res;
                    r_ovf    <= w_alu_ovf;
                    r_state  <= S_WRITE;
                end
                S_WRITE: begin
                    if (w_op != OP_DISP)
                        r_regs[w_rd] <= r_result;
                    flag_z      <= (r_result == '0);
                    flag_v      <= r_ovf;
                    lcd_opcode  <= w_op;
                    lcd_reg_idx <= (w_op == OP_DISP) ? w_rs1 : w_rd;
                    lcd_value   <= r_result;
                    lcd_update  <= 1'b1;
                    r_state     <= S_PULSE;
                end
                S_PULSE: begin
                    r_to    <= '0;
                    r_state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (lcd_busy)
                        r_state <= S_WAIT_LO;
                    else if (r_to == TO_LAST)
                        r_state <= S_IDLE;
                    else
                        r_to <= r_to + 1'b1;
                end
                S_WAIT_LO: begin
                    if (!lcd_busy)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
